// File: rtl/mbist_pkg.sv
// Shared types for the March-C- BIST engine: FSM states, march elements and
// the per-element op table.
package mbist_pkg;

    localparam int NUM_ARR = 3;

    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FREEZE, ST_HALT} state_e;
    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

    typedef struct packed {
        logic down;     // address runs DEPTH-1 -> 0
        logic two_ops;  // r,w pair per address
        logic has_rd;   // op 0 is a read
        logic rd_pol;   // expected read value is ~B
        logic wr_pol;   // written value is ~B
    } elem_cfg_t;

    function automatic logic elem_down(input elem_e e);
        return (e == M3) || (e == M4) || (e == M5);
    endfunction

    function automatic elem_cfg_t elem_cfg(input elem_e e);
        elem_cfg_t c;
        c.down    = elem_down(e);
        c.two_ops = (e != M0) && (e != M5);
        c.has_rd  = (e != M0);
        c.rd_pol  = (e == M2) || (e == M4);
        c.wr_pol  = (e == M1) || (e == M3);
        return c;
    endfunction

    function automatic elem_e next_elem(input elem_e e);
        case (e)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            default: return M0;
        endcase
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Per-array read checker: registers the outstanding read's expectation and
// address, flags a miscompare when the data returns, keeps a sticky error.
module mbist_cmp #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_rd_en,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_fail,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_vld;
    logic [DATA_W-1:0] r_exp;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    assign o_fail = r_vld && (i_rdata != r_exp);
    assign o_err  = r_err;
    assign o_addr = r_addr;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_exp  <= '0;
            r_addr <= '0;
            r_err  <= 1'b0;
        end else begin
            r_vld <= i_rd_en;
            if (i_rd_en) begin
                r_exp  <= i_exp;
                r_addr <= i_addr;
            end
            // a new run clears the flag even if a stale compare lands on the same edge
            if (i_clr)       r_err <= 1'b0;
            else if (o_fail) r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mbist_engine.sv
// March-C- BIST engine driving one shared bus to three arrays; handles launch,
// march sequencing, stop/freeze policies and sticky status.
module mbist_engine
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              mbist_start,
    input  logic              mbist_bisi_mode,
    input  logic              mbist_stop_on_next_fail,
    input  logic              mbist_stop_on_fail,
    input  logic              mbist_loop_mode,
    input  logic              mbist_loop_on_addr,
    input  logic              mbist_data_mode,
    input  logic [DATA_W-1:0] mbist_user_data,
    input  logic [DATA_W-1:0] mbist_rdata_0,
    input  logic [DATA_W-1:0] mbist_rdata_1,
    input  logic [DATA_W-1:0] mbist_rdata_2,
    output logic [ADDR_W-1:0] mbist_addr,
    output logic [DATA_W-1:0] mbist_wdata,
    output logic              mbist_wr_en,
    output logic              mbist_rd_en,
    output logic              mbist_busy,
    output logic              mbist_done,
    output logic [2:0]        mbist_err,
    output logic [ADDR_W-1:0] mbist_fail_addr
);

    state_e            r_state, w_next;
    elem_e             r_elem, r_rd_elem, w_nxt_elem;
    logic              r_op, r_start_d, r_done;
    logic              r_bisi, r_stop_next, r_stop_fail, r_loop, r_loop_addr;
    logic [DATA_W-1:0] r_bg;
    logic [ADDR_W-1:0] r_addr, r_fail_addr, w_fail_src;
    logic [1:0]        r_fail_cnt;

    elem_cfg_t                        w_cfg;
    logic                             w_launch, w_issue, w_is_rd, w_rd_en, w_wr_en;
    logic                             w_addr_end, w_last_op, w_pass_end, w_chk_st;
    logic                             w_fail_evt, w_stop, w_freeze, w_squash;
    logic [DATA_W-1:0]                w_exp;
    logic [NUM_ARR-1:0]               w_fail_vec;
    logic [NUM_ARR-1:0][ADDR_W-1:0]   w_cmp_addr;
    logic [NUM_ARR-1:0][DATA_W-1:0]   w_rdata;

    assign w_launch   = mbist_start && !r_start_d && (r_state == ST_IDLE || r_state == ST_HALT);
    assign w_cfg      = elem_cfg(r_elem);
    assign w_nxt_elem = next_elem(r_elem);
    assign w_issue    = (r_state == ST_RUN) || (r_state == ST_FREEZE);
    assign w_is_rd    = w_cfg.has_rd && !r_op;
    assign w_addr_end = w_cfg.down ? (r_addr == '0) : (r_addr == {ADDR_W{1'b1}});
    assign w_last_op  = !w_cfg.two_ops || r_op;
    assign w_pass_end = w_last_op && w_addr_end && (r_elem == M5 || (r_bisi && r_elem == M0));
    assign w_exp      = w_cfg.rd_pol ? ~r_bg : r_bg;

    assign w_chk_st   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_fail_evt = |w_fail_vec;
    assign w_stop     = w_fail_evt && w_chk_st && !r_loop_addr &&
                        (r_stop_fail || (r_stop_next && r_fail_cnt == 2'd1));
    assign w_freeze   = w_fail_evt && w_chk_st && r_loop_addr && (r_fail_cnt == 2'd0);
    // the op sharing the cycle with a stopping compare must never reach the arrays
    assign w_squash   = w_stop && (r_state == ST_RUN);

    assign w_rd_en = w_issue && w_is_rd && !w_squash;
    assign w_wr_en = w_issue && !w_is_rd && !w_squash;

    assign mbist_addr      = r_addr;
    assign mbist_wdata     = w_issue ? (w_cfg.wr_pol ? ~r_bg : r_bg) : '0;
    assign mbist_rd_en     = w_rd_en;
    assign mbist_wr_en     = w_wr_en;
    assign mbist_busy      = w_chk_st || (r_state == ST_FREEZE);
    assign mbist_done      = r_done;
    assign mbist_fail_addr = r_fail_addr;

    assign w_rdata = {mbist_rdata_2, mbist_rdata_1, mbist_rdata_0};

    for (genvar g = 0; g < NUM_ARR; g++) begin : g_cmp
        mbist_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
            .rclk    (rclk),
            .rst     (rst),
            .i_clr   (w_launch),
            .i_rd_en (w_rd_en),
            .i_exp   (w_exp),
            .i_addr  (r_addr),
            .i_rdata (w_rdata[g]),
            .o_fail  (w_fail_vec[g]),
            .o_err   (mbist_err[g]),
            .o_addr  (w_cmp_addr[g])
        );
    end

    always_comb begin
        w_fail_src = w_cmp_addr[2];
        if (w_fail_vec[1]) w_fail_src = w_cmp_addr[1];
        if (w_fail_vec[0]) w_fail_src = w_cmp_addr[0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_next = ST_RUN;
            ST_RUN: begin
                if (!mbist_start && !r_loop) w_next = ST_IDLE;
                else if (w_stop)             w_next = ST_HALT;
                else if (w_freeze)           w_next = ST_FREEZE;
                else if (w_pass_end)         w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!mbist_start && !r_loop)  w_next = ST_IDLE;
                else if (w_stop)              w_next = ST_HALT;
                else if (w_freeze)            w_next = ST_FREEZE;
                else if (r_loop && mbist_start) w_next = ST_RUN;
                else                          w_next = ST_HALT;
            end
            ST_FREEZE: if (!mbist_start) w_next = ST_HALT;
            ST_HALT:   if (w_launch) w_next = ST_RUN;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_elem      <= M0;
            r_rd_elem   <= M0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_bg        <= '0;
            r_bisi      <= 1'b0;
            r_stop_next <= 1'b0;
            r_stop_fail <= 1'b0;
            r_loop      <= 1'b0;
            r_loop_addr <= 1'b0;
            r_fail_cnt  <= 2'd0;
            r_fail_addr <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= mbist_start;
            if (w_rd_en) r_rd_elem <= r_elem;
            if (w_launch) begin
                r_bisi      <= mbist_bisi_mode;
                r_stop_next <= mbist_stop_on_next_fail;
                r_stop_fail <= mbist_stop_on_fail;
                r_loop      <= mbist_loop_mode;
                r_loop_addr <= mbist_loop_on_addr;
                r_bg        <= mbist_data_mode ? mbist_user_data : '0;
                r_elem      <= M0;
                r_op        <= 1'b0;
                r_addr      <= '0;
                r_fail_cnt  <= 2'd0;
                r_fail_addr <= '0;
                r_done      <= 1'b0;
            end else begin
                if (w_fail_evt && r_fail_cnt != 2'd3) r_fail_cnt <= r_fail_cnt + 2'd1;
                if (w_fail_evt && r_fail_cnt == 2'd0) r_fail_addr <= w_fail_src;
                if (r_state == ST_HALT) r_done <= 1'b1;
                if (w_next == ST_FREEZE && r_state != ST_FREEZE) begin
                    // rewind to the read that failed and replay its element from op 0
                    r_addr <= w_fail_src;
                    r_elem <= r_rd_elem;
                    r_op   <= 1'b0;
                end else if (r_state == ST_RUN) begin
                    if (!w_last_op) begin
                        r_op <= 1'b1;
                    end else begin
                        r_op <= 1'b0;
                        if (w_pass_end) begin
                            r_elem <= M0;
                            r_addr <= '0;
                        end else if (w_addr_end) begin
                            r_elem <= w_nxt_elem;
                            r_addr <= elem_down(w_nxt_elem) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
                        end else begin
                            r_addr <= w_cfg.down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
                        end
                    end
                end else if (r_state == ST_FREEZE) begin
                    r_op <= w_cfg.two_ops ? ~r_op : 1'b0;
                end
            end
        end
    end

endmodule
